dphy_lprx: RTL and testbench



---
 rtl/dphy_lprx.sv | 196 +++++++++++++++++++
 tb/tb_dphy_lprx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_lprx.sv
// D-PHY data-lane LP receiver: line-state monitor, SoT entry and HS timing.
// Optional LP-10 escape-entry detection: define DPHY_LPRX_ESC_DETECT_EN.
module dphy_lprx #(
  parameter int unsigned LPX_MIN       = 4,
  parameter int unsigned TERM_EN_TIME  = 3,
  parameter int unsigned HSSETTLE_TIME = 10,
  parameter int unsigned STOP_FILTER   = 2
) (
  input  logic       LPRX_CLK,
  input  logic       RxRst_n,
  input  logic       LPRX_EN,
  input  logic       LP_Dp,
  input  logic       LP_Dn,
  output logic       RxStopState,
  output logic       HSRX_EN,
  output logic       RxActiveHS,
  output logic       ErrControl,
`ifdef DPHY_LPRX_ESC_DETECT_EN
  output logic       EscRequest,
`endif
  output logic [1:0] LP_State
);

  localparam logic [4:0] LC_LPX  = 5'(LPX_MIN);
  localparam logic [4:0] LC_TERM = 5'(TERM_EN_TIME);
  localparam logic [4:0] LC_HSS1 = 5'(HSSETTLE_TIME - 1);
  localparam logic [4:0] LC_STOP = 5'(STOP_FILTER);
  localparam logic [4:0] LC_SAT  = 5'd31;

  typedef enum logic [2:0] {
    RX_WAIT_STOP = 3'd0,
    RX_STOP      = 3'd1,
    RX_HS_RQST   = 3'd2,
    RX_HS_PRPR   = 3'd3,
    RX_HS_ACTIVE = 3'd4,
    RX_ESC_RQST  = 3'd5
  } rx_state_e;

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  rx_state_e  r_state;
  rx_state_e  w_nxt;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  logic [4:0] r_stop_cnt;
  logic [4:0] w_stop_run;
  logic       w_stop_ok;
  logic       w_err;
  logic       r_stop;
  logic       r_hsrx;
  logic       r_act;
  logic       r_err;
`ifdef DPHY_LPRX_ESC_DETECT_EN
  logic       w_esc;
  logic       r_esc;
`endif

  // Two-flop synchronizer for the asynchronous comparator outputs
  always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
    if (!RxRst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {LP_Dp, LP_Dn};
      r_sync2 <= r_sync1;
    end
  end

  // Length of the current LP-11 run including this cycle
  always_comb begin
    w_stop_run = 5'd0;
    if (r_sync2 == 2'b11) begin
      w_stop_run = (r_stop_cnt == LC_SAT) ? LC_SAT
                                           : r_stop_cnt + 5'd1;
    end
    w_stop_ok = (w_stop_run >= LC_STOP);
  end

  // Next-state and error/escape decode from the synchronized line
  always_comb begin
    w_nxt = r_state;
    w_err = 1'b0;
`ifdef DPHY_LPRX_ESC_DETECT_EN
    w_esc = 1'b0;
`endif
    if (!LPRX_EN) begin
      w_nxt = RX_WAIT_STOP;
    end else begin
      unique case (r_state)
        RX_WAIT_STOP: begin
          if (w_stop_ok) w_nxt = RX_STOP;
        end
        RX_STOP: begin
          if (r_sync2 == 2'b01) begin
            w_nxt = RX_HS_RQST;
          end else if (r_sync2 == 2'b00) begin
            w_err = 1'b1;
            w_nxt = RX_WAIT_STOP;
          end
`ifdef DPHY_LPRX_ESC_DETECT_EN
          else if (r_sync2 == 2'b10) begin
            w_nxt = RX_ESC_RQST;
          end
`endif
        end
        RX_HS_RQST: begin
          if (r_sync2 == 2'b11) begin
            w_nxt = RX_STOP;
          end else if (r_sync2 == 2'b10) begin
            w_err = 1'b1;
            w_nxt = RX_WAIT_STOP;
          end else if (r_sync2 == 2'b00) begin
            if (r_cnt >= LC_LPX) begin
              w_nxt = RX_HS_PRPR;
            end else begin
              w_err = 1'b1;
              w_nxt = RX_WAIT_STOP;
            end
          end
        end
        RX_HS_PRPR: begin
          if (r_sync2 != 2'b00) begin
            w_err = 1'b1;
            w_nxt = RX_WAIT_STOP;
          end else if (r_cnt >= LC_HSS1) begin
            w_nxt = RX_HS_ACTIVE;
          end
        end
        RX_HS_ACTIVE: begin
          if (w_stop_ok) w_nxt = RX_STOP;
        end
`ifdef DPHY_LPRX_ESC_DETECT_EN
        RX_ESC_RQST: begin
          if (r_sync2 == 2'b11) begin
            w_nxt = RX_STOP;
          end else if (r_sync2 == 2'b01) begin
            w_err = 1'b1;
            w_nxt = RX_WAIT_STOP;
          end else if (r_sync2 == 2'b00) begin
            if (r_cnt >= LC_LPX) w_esc = 1'b1;
            else                 w_err = 1'b1;
            w_nxt = RX_WAIT_STOP;
          end
        end
`endif
        default: w_nxt = RX_WAIT_STOP;
      endcase
    end
  end

  // Dwell counter restarts on every state change and saturates
  always_comb begin
    w_cnt_nxt = 5'd0;
    if (w_nxt == r_state) begin
      w_cnt_nxt = (r_cnt == LC_SAT) ? LC_SAT : r_cnt + 5'd1;
    end
  end

  // State, counters and registered outputs, all derived from next state
  always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
    if (!RxRst_n) begin
      r_state    <= RX_WAIT_STOP;
      r_cnt      <= 5'd0;
      r_stop_cnt <= 5'd0;
      r_stop     <= 1'b0;
      r_hsrx     <= 1'b0;
      r_act      <= 1'b0;
      r_err      <= 1'b0;
`ifdef DPHY_LPRX_ESC_DETECT_EN
      r_esc      <= 1'b0;
`endif
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stop_cnt <= w_stop_run;
      r_stop     <= (w_nxt == RX_STOP);
      r_act      <= (w_nxt == RX_HS_ACTIVE);
      r_hsrx     <= (w_nxt == RX_HS_ACTIVE) ||
                    ((w_nxt == RX_HS_PRPR) && (w_cnt_nxt >= LC_TERM));
      r_err      <= w_err;
`ifdef DPHY_LPRX_ESC_DETECT_EN
      r_esc      <= w_esc;
`endif
    end
  end

  assign RxStopState = r_stop;
  assign HSRX_EN     = r_hsrx;
  assign RxActiveHS  = r_act;
  assign ErrControl  = r_err;
  assign LP_State    = r_sync2;
`ifdef DPHY_LPRX_ESC_DETECT_EN
  assign EscRequest  = r_esc;
`endif

endmodule

// File: tb/tb_dphy_lprx.sv
// Randomized bench for dphy_lprx against a line-history reference model.
// Builds with or without DPHY_LPRX_ESC_DETECT_EN.
module tb_dphy_lprx;

  localparam int LPX  = 4;
  localparam int TERM = 3;
  localparam int HSS  = 10;
  localparam int SF   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dp = 1'b0;
  logic       dn = 1'b0;
  logic       stop;
  logic       hsrx;
  logic       act;
  logic       err;
  logic [1:0] lps;
`ifdef DPHY_LPRX_ESC_DETECT_EN
  logic       esc;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dphy_lprx #(
    .LPX_MIN      (LPX),
    .TERM_EN_TIME (TERM),
    .HSSETTLE_TIME(HSS),
    .STOP_FILTER  (SF)
  ) dut (
    .LPRX_CLK   (clk),
    .RxRst_n    (rst_n),
    .LPRX_EN    (en),
    .LP_Dp      (dp),
    .LP_Dn      (dn),
    .RxStopState(stop),
    .HSRX_EN    (hsrx),
    .RxActiveHS (act),
    .ErrControl (err),
`ifdef DPHY_LPRX_ESC_DETECT_EN
    .EscRequest (esc),
`endif
    .LP_State   (lps)
  );

  // Reference model: lane phase plus the edge at which it began.
  typedef enum int {M_WAIT, M_STOP, M_RQST, M_PREP, M_HS, M_ESC} mode_e;
  mode_e      mode;
  int         cyc;
  int         t_ent;
  int         run11;
  logic [1:0] hist[$];
  logic [1:0] ex_lps;
  logic       e_err;
  logic       e_esc;

  // Pulse/level tallies for the directed scenarios
  int c_err;
  int c_esc;
  int c_hs;
  int c_act;
  int c_nact;
  int c_nstop;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode   = M_WAIT;
    cyc    = 0;
    t_ent  = 0;
    run11  = 0;
    hist   = '{2'b00, 2'b00};
    ex_lps = 2'b00;
    e_err  = 1'b0;
    e_esc  = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] v;
    mode_e      nm;
    int         age;
    cyc++;
    hist.push_back({dp, dn});
    v      = hist[hist.size() - 3];
    ex_lps = hist[hist.size() - 2];
    while (hist.size() > 2) hist.pop_front();
    run11 = (v == 2'b11) ? run11 + 1 : 0;
    age   = cyc - t_ent;
    nm    = mode;
    e_err = 1'b0;
    e_esc = 1'b0;
    if (!en) begin
      nm = M_WAIT;
    end else begin
      case (mode)
        M_WAIT: if (run11 >= SF) nm = M_STOP;
        M_STOP: begin
          if (v == 2'b01) nm = M_RQST;
          else if (v == 2'b00) begin e_err = 1; nm = M_WAIT; end
`ifdef DPHY_LPRX_ESC_DETECT_EN
          else if (v == 2'b10) nm = M_ESC;
`endif
        end
        // age-1 = LP-01 samples seen after the one that opened the request
        M_RQST: begin
          if (v == 2'b11) nm = M_STOP;
          else if (v == 2'b10) begin e_err = 1; nm = M_WAIT; end
          else if (v == 2'b00) begin
            if (age - 1 >= LPX) nm = M_PREP;
            else begin e_err = 1; nm = M_WAIT; end
          end
        end
        M_PREP: begin
          if (v != 2'b00) begin e_err = 1; nm = M_WAIT; end
          else if (age >= HSS) nm = M_HS;
        end
        M_HS: if (run11 >= SF) nm = M_STOP;
        M_ESC: begin
          if (v == 2'b11) nm = M_STOP;
          else if (v == 2'b01) begin e_err = 1; nm = M_WAIT; end
          else if (v == 2'b00) begin
            if (age - 1 >= LPX) e_esc = 1; else e_err = 1;
            nm = M_WAIT;
          end
        end
        default: nm = M_WAIT;
      endcase
    end
    if (nm != mode) begin
      mode  = nm;
      t_ent = cyc;
    end
  endtask

  // One clock: advance the model and compare every output
  task automatic tick();
    logic x_hs;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
    x_hs = (mode == M_HS) || (mode == M_PREP && (cyc - t_ent) >= TERM);
    chk("stop", stop, mode == M_STOP);
    chk("hsrx", hsrx, x_hs);
    chk("act", act, mode == M_HS);
    chk("err", err, e_err);
    chk("lps", lps, ex_lps);
`ifdef DPHY_LPRX_ESC_DETECT_EN
    chk("esc", esc, e_esc);
    if (esc) c_esc++;
`endif
    if (err) c_err++;
    if (hsrx) c_hs++;
    if (act) c_act++;
    if (!act) c_nact++;
    if (!stop) c_nstop++;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    {dp, dn} = v;
    repeat (n) tick();
  endtask

  task automatic clr();
    c_err = 0; c_esc = 0; c_hs = 0;
    c_act = 0; c_nact = 0; c_nstop = 0;
  endtask

  initial begin
    int k_a;
    int k_b;
    model_reset();
    clr();
    // Reset state
    hold(2'b00, 3);
    chk("rst_stop", stop, 0);
    chk("rst_hsrx", hsrx, 0);
    chk("rst_lps", lps, 2'b00);
    rst_n = 1'b1;
    en    = 1'b1;

    // 1: LP-11 qualifies Stop four edges after the pad change
    clr();
    k_a = -1;
    {dp, dn} = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (k_a < 0 && stop) k_a = i;
    end
    chk("t1_stop_lat", k_a, 4);
    chk("t1_no_err", c_err, 0);

    // 2: valid SoT, HS timing, and stop exit
    hold(2'b01, 6);
    k_a = -1; k_b = -1;
    {dp, dn} = 2'b00;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (k_a < 0 && hsrx) k_a = i;
      if (k_b < 0 && act) k_b = i;
    end
    chk("t2_hsrx_lat", k_a, 6);
    chk("t2_act_lat", k_b, 13);
    k_a = -1; k_b = -1;
    {dp, dn} = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (k_a < 0 && stop) k_a = i;
      if (k_b < 0 && !act) k_b = i;
    end
    chk("t2_stop_lat", k_a, 4);
    chk("t2_act_drop", k_b, 4);
    chk("t2_hsrx_end", hsrx, 0);

    // 3: LP-01 too short
    clr();
    hold(2'b01, 2);
    hold(2'b00, 8);
    chk("t3_err_cnt", c_err, 1);
    chk("t3_no_hsrx", c_hs, 0);
    chk("t3_not_stop", stop, 0);
    k_a = -1;
    {dp, dn} = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (k_a < 0 && stop) k_a = i;
    end
    chk("t3_stop_lat", k_a, 4);

    // 4: line leaves LP-00 before settle completes
    clr();
    hold(2'b01, 6);
    hold(2'b00, 5);
    hold(2'b01, 6);
    chk("t4_err_cnt", c_err, 1);
    chk("t4_no_act", c_act, 0);
    chk("t4_hsrx_off", hsrx, 0);
    hold(2'b11, 6);

    // 5: single-cycle LP-11 glitch, then receiver disable
    hold(2'b01, 6);
    hold(2'b00, 14);
    chk("t5_act_on", act, 1);
    clr();
    hold(2'b11, 1);
    hold(2'b00, 6);
    chk("t5_glitch", c_nact, 0);
    en = 1'b0;
    tick();
    chk("t5_dis_act", act, 0);
    chk("t5_dis_hsrx", hsrx, 0);
    chk("t5_dis_stop", stop, 0);
    hold(2'b00, 4);
    chk("t5_dis_err", c_err, 0);
    en = 1'b1;
    hold(2'b11, 6);

    // Asynchronous reset during a burst
    hold(2'b01, 6);
    hold(2'b00, 14);
    chk("ar_act_on", act, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_act", act, 0);
    chk("ar_hsrx", hsrx, 0);
    chk("ar_lps", lps, 2'b00);
    hold(2'b11, 2);
    rst_n = 1'b1;
    hold(2'b11, 6);

    // 6: LP-10 from Stop, then LP-00
    clr();
    hold(2'b10, 5);
`ifdef DPHY_LPRX_ESC_DETECT_EN
    hold(2'b00, 4);
    chk("t6_esc_cnt", c_esc, 1);
    chk("t6_err_cnt", c_err, 0);
`else
    chk("t6_stop_held", c_nstop, 0);
    hold(2'b00, 4);
    chk("t6_err_cnt", c_err, 1);
`endif
    hold(2'b11, 6);

    // Random line activity with occasional disable
    for (int s = 0; s < 300; s++) begin
      logic [1:0] v;
      int         len;
      v   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 12);
      en  = ($urandom_range(0, 15) != 0);
      hold(v, len);
    end
    // Randomized, mostly legal bursts
    for (int b = 0; b < 60; b++) begin
      en = 1'b1;
      hold(2'b11, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) hold(2'b10, $urandom_range(1, 7));
      hold(2'b01, $urandom_range(1, 8));
      hold(2'b00, $urandom_range(3, 20));
      if ($urandom_range(0, 1) == 1) hold(2'b11, 1);
      hold(2'b00, $urandom_range(0, 5));
      hold(2'b11, $urandom_range(1, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
